// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter and next-PC stage of the single-cycle MIPS core.
// Holds the PC, walks the core through IDLE -> RUN -> HALTED, and gates all
// architectural writes through commit.
//
// Ports:
//   clk, reset     core clock (rising edge), asynchronous active-high reset
//   start          one-cycle pulse that begins or restarts execution
//   instr          instruction currently addressed by pc
//   Jump, JumpR    j/jal and jr from the control unit
//   Branch, zero   beq from the control unit and the ALU zero flag
//   rs_data        register-file rs read data (jr target)
//   Done           halt opcode decoded
//   pc, pc_plus4   current PC and PC+4 (jal link data)
//   commit         current instruction may write regfile/memory
//   running        core is in RUN
//   halted         core is in HALTED
//   misalign_err   sticky: a jr target had nonzero low bits
//   instr_count    instructions retired since the last reset or start
module pc_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h00000000,
  parameter int          COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [31:0]            instr,
  input  logic                   Jump,
  input  logic                   JumpR,
  input  logic                   Branch,
  input  logic                   zero,
  input  logic [31:0]            rs_data,
  input  logic                   Done,
  output logic [31:0]            pc,
  output logic [31:0]            pc_plus4,
  output logic                   commit,
  output logic                   running,
  output logic                   halted,
  output logic                   misalign_err,
  output logic [COUNT_WIDTH-1:0] instr_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t                 state, state_next;
  logic [31:0]            pc_next;
  logic [COUNT_WIDTH-1:0] count_next;
  logic                   err_next;
  logic [31:0]            target;
  logic [31:0]            branch_offset;
  logic                   jr_misalign;

  assign pc_plus4      = pc + 32'd4;
  assign running       = (state == RUN);
  assign halted        = (state == HALTED);
  assign branch_offset = {{14{instr[15]}}, instr[15:0], 2'b00};

  // A jr to an unaligned address is only an error while actually executing.
  assign jr_misalign = running & JumpR & (rs_data[1:0] != 2'b00);
  assign commit      = running & ~Done & ~jr_misalign;

  // Next-PC selection: JumpR beats Jump beats a taken branch beats fall-through.
  always_comb begin
    target = pc_plus4;
    if (JumpR) begin
      target = {rs_data[31:2], 2'b00};
    end else if (Jump) begin
      target = {pc_plus4[31:28], instr[25:0], 2'b00};
    end else if (Branch && zero) begin
      target = pc_plus4 + branch_offset;
    end
  end

  // Sequencer: Done has absolute priority in RUN, then a misaligned jr;
  // otherwise the instruction retires and the PC advances.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    count_next = instr_count;
    err_next   = misalign_err;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          pc_next    = RESET_PC;
          count_next = '0;
        end
      end
      RUN: begin
        if (Done) begin
          state_next = HALTED;
        end else if (jr_misalign) begin
          state_next = HALTED;
          err_next   = 1'b1;
        end else begin
          pc_next    = target;
          count_next = instr_count + COUNT_WIDTH'(1);
        end
      end
      HALTED: begin
        if (start) begin
          state_next = RUN;
          pc_next    = RESET_PC;
          count_next = '0;
          err_next   = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      instr_count  <= '0;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_next;
      pc           <= pc_next;
      instr_count  <= count_next;
      misalign_err <= err_next;
    end
  end

endmodule
